// File: rtl/uart_packet_rx.sv
`timescale 1ns/1ps
// UART 8N1 receiver that packs PKT_BYTES bytes into one command packet
// and offers it on a valid/ready slot with timeout/overrun handling.
module uart_packet_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PKT_BYTES    = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   CLK,
  input  logic                   RST_BAR,
  input  logic                   RX,
  output logic [8*PKT_BYTES-1:0] PKT_DATA,
  output logic                   PKT_VALID,
  input  logic                   PKT_READY,
  output logic                   BUSY,
  output logic                   FRAME_ERR,
  output logic                   TIMEOUT,
  output logic                   OVERRUN
);

  localparam int W  = 8*PKT_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TL = TIMEOUT_BITS*CLKS_PER_BIT;
  localparam int TW = $clog2(TL);
  localparam int IW = $clog2(PKT_BYTES);

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT-1);
  localparam logic [TW-1:0] TMAX = TW'(TL-1);
  localparam logic [IW-1:0] LAST = IW'(PKT_BYTES-1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sreg;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] idx;
  logic [W-1:0]  shadow;
  logic [W-1:0]  pkt_n;

  logic cnt_clr, shift, done, ferr, tout, last, free;

  assign rx_s = sync[1];

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    shift   = 1'b0;
    done    = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_clr = 1'b1;
          shift   = 1'b1;
          if (bitn == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            done    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Timeout beats a start edge seen on the same cycle.
  assign tout = (state == IDLE) && (idx != '0) && (tcnt == TMAX);
  assign last = done && (idx == LAST);
  assign free = !PKT_VALID || PKT_READY;

  always_comb begin
    pkt_n = shadow;
    pkt_n[8*idx +: 8] = sreg;
  end

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      sync      <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sreg      <= '0;
      tcnt      <= '0;
      idx       <= '0;
      shadow    <= '0;
      PKT_DATA  <= '0;
      PKT_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      TIMEOUT   <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      sync  <= {sync[0], RX};
      state <= state_n;

      if (state == IDLE || state == WAIT_HIGH || cnt_clr)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state != DATA) bitn <= '0;
      else if (shift)    bitn <= bitn + 1'b1;

      if (shift) sreg <= {rx_s, sreg[7:1]};

      if (state != IDLE || idx == '0 || tout)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;

      if (tout) begin
        idx    <= '0;
        shadow <= '0;
      end else if (ferr) begin
        idx <= '0;
      end else if (done) begin
        shadow[8*idx +: 8] <= sreg;
        idx <= last ? '0 : idx + 1'b1;
      end

      FRAME_ERR <= ferr;
      TIMEOUT   <= tout;
      OVERRUN   <= last && !free;

      if (last && free) begin
        PKT_DATA  <= pkt_n;
        PKT_VALID <= 1'b1;
      end else if (PKT_READY) begin
        PKT_VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state != IDLE) || (idx != '0);

endmodule

// File: tb/tb_uart_packet_rx.sv
`timescale 1ns/1ps
// Randomised bench for uart_packet_rx against a byte-queue packet model.
// Bit period is shortened to 20 clocks so full packets fit a short run.
module tb_uart_packet_rx;

  localparam int CPB = 20;
  localparam int NB  = 16;
  localparam int TOB = 20;
  localparam int BIT = CPB*10;

  logic         CLK = 1'b0;
  logic         RST_BAR = 1'b0;
  logic         RX = 1'b1;
  logic [127:0] PKT_DATA;
  logic         PKT_VALID;
  logic         PKT_READY = 1'b1;
  logic         BUSY, FRAME_ERR, TIMEOUT, OVERRUN;

  uart_packet_rx #(
    .CLKS_PER_BIT(CPB),
    .PKT_BYTES(NB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .CLK(CLK),
    .RST_BAR(RST_BAR),
    .RX(RX),
    .PKT_DATA(PKT_DATA),
    .PKT_VALID(PKT_VALID),
    .PKT_READY(PKT_READY),
    .BUSY(BUSY),
    .FRAME_ERR(FRAME_ERR),
    .TIMEOUT(TIMEOUT),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   acc[$];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  int exp_fe = 0, exp_to = 0, exp_ov = 0;
  int got_fe = 0, got_to = 0, got_ov = 0;
  bit slot_full = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (PKT_VALID && PKT_READY) got_q.push_back(PKT_DATA);
    if (FRAME_ERR) got_fe++;
    if (TIMEOUT)   got_to++;
    if (OVERRUN)   got_ov++;
  end

  function automatic void model_byte(input logic [7:0] b);
    logic [127:0] p;
    acc.push_back(b);
    if (acc.size() == NB) begin
      p = '0;
      for (int i = 0; i < NB; i++) p[8*i +: 8] = acc[i];
      if (!slot_full || PKT_READY) begin
        exp_q.push_back(p);
        slot_full = !PKT_READY;
      end else begin
        exp_ov++;
      end
      acc.delete();
    end
  endfunction

  task automatic idle_bits(input int n, input int bn);
    RX = 1'b1;
    #(n*bn);
    if (n >= TOB && acc.size() > 0) begin
      exp_to++;
      acc.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bn,
                            input bit bad);
    RX = 1'b0;
    #(bn);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      #(bn);
    end
    if (!bad) begin
      RX = 1'b1;
      #(bn);
      model_byte(b);
    end else begin
      RX = 1'b0;
      #(4*bn);
      RX = 1'b1;
      #(bn);
      exp_fe++;
      acc.delete();
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input bit rnd,
                          input int bn);
    send_frame(hdr, bn, 1'b0);
    for (int i = 1; i < NB; i++)
      send_frame(rnd ? 8'($urandom) : 8'hFF, bn, 1'b0);
  endtask

  task automatic drain(input string tag);
    logic [127:0] g, e;
    repeat (6) @(negedge CLK);
    check({tag, "_npkt"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_pkt"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_ferr"}, got_fe, exp_fe);
    check({tag, "_tout"}, got_to, exp_to);
    check({tag, "_ovr"}, got_ov, exp_ov);
  endtask

  initial begin
    #23;
    check("rst_data", PKT_DATA, 128'h0);
    check("rst_outs", {PKT_VALID, BUSY, FRAME_ERR, TIMEOUT, OVERRUN}, 5'b0);
    @(negedge CLK);
    RST_BAR = 1'b1;
    idle_bits(2, BIT);

    send_pkt(8'h04, 1'b0, BIT);
    idle_bits(2, BIT);
    drain("basic");

    PKT_READY = 1'b0;
    send_pkt(8'h06, 1'b0, 196);
    idle_bits(1, 196);
    send_pkt(8'h03, 1'b0, 204);
    idle_bits(2, BIT);
    check("ovr_valid", PKT_VALID, 1'b1);
    check("ovr_hdr", PKT_DATA[7:0], 8'h06);
    check("ovr_cnt", got_ov, exp_ov);
    @(posedge CLK);
    #1 PKT_READY = 1'b1;
    slot_full = 0;
    @(negedge CLK);
    @(negedge CLK);
    check("ovr_drop", PKT_VALID, 1'b0);
    drain("ovr");

    RX = 1'b0;
    #40;
    RX = 1'b1;
    #(2*BIT);
    check("glitch_busy", BUSY, 1'b0);
    drain("glitch");

    for (int i = 0; i < 5; i++) send_frame(8'($urandom), BIT, 1'b0);
    check("to_busy", BUSY, 1'b1);
    idle_bits(22, BIT);
    check("to_idle", BUSY, 1'b0);
    send_pkt(8'h05, 1'b1, BIT);
    idle_bits(2, BIT);
    drain("tout");

    for (int i = 0; i < 3; i++) send_frame(8'($urandom), BIT, 1'b0);
    send_frame(8'hA5, BIT, 1'b1);
    check("fe_busy", BUSY, 1'b0);
    send_pkt(8'h5A, 1'b1, BIT);
    idle_bits(2, BIT);
    drain("ferr");

    for (int i = 0; i < 9; i++) send_frame(8'($urandom), BIT, 1'b0);
    RX = 1'b0;
    #(3*BIT + 17);
    RST_BAR = 1'b0;
    #3;
    check("mid_rst_data", PKT_DATA, 128'h0);
    check("mid_rst_outs",
          {PKT_VALID, BUSY, FRAME_ERR, TIMEOUT, OVERRUN}, 5'b0);
    acc.delete();
    slot_full = 0;
    RX = 1'b1;
    repeat (4) @(negedge CLK);
    RST_BAR = 1'b1;
    idle_bits(2, BIT);
    send_pkt(8'hC3, 1'b1, BIT);
    idle_bits(2, BIT);
    drain("reset");

    for (int k = 0; k < 64; k++) begin
      int bn, r;
      bn = $urandom_range(196, 204);
      r  = $urandom_range(0, 15);
      if (r == 0)
        idle_bits($urandom_range(22, 26), bn);
      else if (r < 4)
        idle_bits($urandom_range(1, 12), bn);
      send_frame(8'($urandom), bn, $urandom_range(0, 19) == 0);
    end
    idle_bits(24, BIT);
    drain("rand");
    check("end_busy", BUSY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
